sc_spi_arb: RTL and testbench
=============================

Name: sc_spi_arb

Overview:
Arbiter and sequencer that shares the single SPI transfer controller among NREQ independent requesters (e.g. CPU register path, flash boot loader, DMA).
- Performs round-robin selection among pending requesters.
- Drives TXSTART and the per-transfer configuration (CSSEL, DWIDTH, CPOL, CPHA, BORDER, CSEXTEND) into the transfer controller.
- Tracks SPIBUSY/SPICOMPLETE and returns a per-requester DONE pulse.
- Honours CSEXTEND as a bus lock, so multi-transfer transactions are not interleaved.

Parameters:
NREQ, 4, number of requesters (2..8)
LOCKTMO, 1024, idle cycles tolerated while locked before forced release (used only with the optional feature)

Ports:
SYSCLK  in  1  system clock
SYSRST  in  1  reset; asynchronous, active-high
REQ  in  NREQ  per-requester transfer request, level
REQ_CSSEL  in  5*NREQ  chip-select index, requester i at [5i+4:5i]
REQ_DWIDTH  in  9*NREQ  data width, requester i at [9i+8:9i]
REQ_CPOL  in  NREQ  clock polarity per requester
REQ_CPHA  in  NREQ  clock phase per requester
REQ_BORDER  in  NREQ  bit order per requester
REQ_CSEXTEND  in  NREQ  keep CS asserted after this transfer (lock request)
GNT  out  NREQ  one-hot grant, registered
DONE  out  NREQ  one-cycle completion pulse to the granted requester
LOCKED  out  1  arbiter is held by a CSEXTEND transaction
TXSTART  out  1  start strobe to the transfer controller
CSSEL  out  5  latched config to the transfer controller
DWIDTH  out  9  latched config to the transfer controller
CPOL  out  1  latched config to the transfer controller
CPHA  out  1  latched config to the transfer controller
BORDER  out  1  latched config to the transfer controller
CSEXTEND  out  1  latched config to the transfer controller
SPIBUSY  in  1  transfer controller busy
SPICOMPLETE  in  1  transfer controller completion pulse

Behaviour:
- Reset values: all outputs 0; state ARB_IDLE; round-robin pointer last = NREQ-1, so requester 0 wins first; lock owner cleared.
- States: ARB_IDLE, ARB_START, ARB_BUSY, ARB_DONE.
- ARB_IDLE:
  - Arbitrates only when REQ is nonzero and SPIBUSY=0. If SPIBUSY is high from a foreign source, it waits.
  - Unlocked: winner = first set REQ bit searching last+1, last+2, … modulo NREQ.
  - Locked: only the lock owner is eligible; other REQs stay pending.
  - On a win at edge n: GNT, config outputs and TXSTART=1 are registered at edge n+1. State → ARB_START; last updated to the winner.
- ARB_START: holds TXSTART=1 until SPIBUSY=1 is sampled. TXSTART clears on that edge; state → ARB_BUSY.
- ARB_BUSY: waits for SPICOMPLETE=1 (SPIBUSY falls in the same cycle); state → ARB_DONE.
- ARB_DONE (one cycle):
  - DONE[winner]=1.
  - If the latched CSEXTEND=1: LOCKED=1, owner=winner, GNT kept.
  - Otherwise: LOCKED=0, GNT cleared.
  - State → ARB_IDLE.
- Requester contract:
  - REQ and config must stay stable from assertion until DONE.
  - Deasserting REQ before GNT withdraws the request.
  - Changes to REQ or config after GNT are ignored; config is latched at grant.
- Releasing the lock: the owner's next transfer with REQ_CSEXTEND=0 releases the lock at its ARB_DONE. The owner deasserting REQ does not release the lock.
- SPICOMPLETE outside ARB_BUSY: ignored.
- SPIBUSY never rising in ARB_START: the arbiter stays in ARB_START; no internal timeout.
- Reset asserted mid-transfer: immediate return to reset values, and the lock is lost. The transfer controller is reset from the same source.
- Back-to-back throughput: minimum 2 idle cycles between one transfer's SPICOMPLETE and the next TXSTART (ARB_DONE, then ARB_IDLE).

Optional Feature:
SC_SPI_ARB_LOCKTMO_EN
- Defined:
  - A clog2(LOCKTMO+1)-bit counter runs while LOCKED=1, the state is ARB_IDLE, and the owner's REQ=0.
  - The counter clears whenever the owner's REQ=1.
  - On reaching LOCKTMO: the lock and GNT are force-released, and output LOCK_ABORT (1 bit, added port) pulses for one cycle.
- Undefined: no counter and no LOCK_ABORT port; the lock is held indefinitely.

Decomposition:
- Shared package sc_spi_pkg:
  - ARB_* state encodings (2-bit).
  - Field widths: CSSEL_W=5, DWIDTH_W=9.
- Sub-module sc_spi_rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], last index, lock enable, owner.
  - Outputs: valid, one-hot winner, winner index.

Test Plan:
- Single request: REQ=0001, CSSEL0=3, DWIDTH0=8 → one edge later GNT=0001, TXSTART=1, CSSEL=3, DWIDTH=8. Stub raises SPIBUSY 2 cycles later → TXSTART clears. SPICOMPLETE → next cycle DONE=0001, GNT=0000.
- Round-robin: REQ=1111 held, each DONE answered by the stub → grant order 0,1,2,3,0.
- Lock: requester 1 with CSEXTEND=1, requester 2 pending → LOCKED=1 after DONE; next grant goes to 1. Requester 1's transfer with CSEXTEND=0 → LOCKED=0, then requester 2 is granted.
- Foreign busy: SPIBUSY=1 with REQ=0001 in ARB_IDLE → no GNT until SPIBUSY=0.
- Reset mid-transfer: SYSRST pulse in ARB_BUSY while LOCKED=1 → all outputs 0 asynchronously; after release, REQ=1000 is granted immediately (lock lost).
- With SC_SPI_ARB_LOCKTMO_EN, LOCKTMO=16: owner holds the lock, REQ=0 for 16 cycles → LOCK_ABORT pulse, LOCKED=0, pending requester 3 granted on the next edge.

Source files
------------

// File: rtl/sc_spi_pkg.sv
// Shared types and field widths for the SPI arbiter slice.
package sc_spi_pkg;

  localparam int unsigned CSSEL_W  = 5;
  localparam int unsigned DWIDTH_W = 9;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_BUSY  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sc_spi_rr_pick.sv
// Combinational round-robin picker; when locked only the owner is eligible.
module sc_spi_rr_pick #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  input  logic            lock_en,
  input  logic [IW-1:0]   owner,
  output logic            valid,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx
);

  always_comb begin
    int unsigned j;
    j      = 0;
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    if (lock_en) begin
      if (req[owner]) begin
        valid = 1'b1;
        idx   = owner;
      end
    end else begin
      // Search starts one past the previous winner and wraps.
      for (int unsigned k = 1; k <= NREQ; k++) begin
        j = (32'(last) + k) % NREQ;
        if (!valid && req[j]) begin
          valid = 1'b1;
          idx   = IW'(j);
        end
      end
    end
    if (valid) onehot = NREQ'(1) << idx;
  end

endmodule

// File: rtl/sc_spi_arb.sv
// Round-robin arbiter/sequencer sharing one SPI transfer controller among NREQ requesters.
// Optional lock timeout enabled by defining SC_SPI_ARB_LOCKTMO_EN (adds LOCK_ABORT).
module sc_spi_arb
  import sc_spi_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LOCKTMO = 1024
) (
  input  logic                     SYSCLK,
  input  logic                     SYSRST,
  input  logic [NREQ-1:0]          REQ,
  input  logic [CSSEL_W*NREQ-1:0]  REQ_CSSEL,
  input  logic [DWIDTH_W*NREQ-1:0] REQ_DWIDTH,
  input  logic [NREQ-1:0]          REQ_CPOL,
  input  logic [NREQ-1:0]          REQ_CPHA,
  input  logic [NREQ-1:0]          REQ_BORDER,
  input  logic [NREQ-1:0]          REQ_CSEXTEND,
  output logic [NREQ-1:0]          GNT,
  output logic [NREQ-1:0]          DONE,
  output logic                     LOCKED,
  output logic                     TXSTART,
  output logic [CSSEL_W-1:0]       CSSEL,
  output logic [DWIDTH_W-1:0]      DWIDTH,
  output logic                     CPOL,
  output logic                     CPHA,
  output logic                     BORDER,
  output logic                     CSEXTEND,
  input  logic                     SPIBUSY,
  input  logic                     SPICOMPLETE
`ifdef SC_SPI_ARB_LOCKTMO_EN
  , output logic                   LOCK_ABORT
`endif
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_t      state, state_nx;
  logic [IW-1:0]   last, owner, win_idx;
  logic            pick_valid;
  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            do_grant, do_complete;
  logic            abort_now;

  sc_spi_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (REQ),
    .last   (last),
    .lock_en(LOCKED),
    .owner  (owner),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

`ifdef SC_SPI_ARB_LOCKTMO_EN
  localparam int unsigned TW = $clog2(LOCKTMO + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_run;

  assign tmo_run   = LOCKED && (state == ARB_IDLE) && !REQ[owner];
  assign abort_now = tmo_run && (tmo_cnt == TW'(LOCKTMO - 1));

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      tmo_cnt    <= '0;
      LOCK_ABORT <= 1'b0;
    end else begin
      LOCK_ABORT <= abort_now;
      if (!tmo_run || abort_now) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign abort_now = 1'b0;
`endif

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) state <= ARB_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    do_grant    = 1'b0;
    do_complete = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (!SPIBUSY && pick_valid) begin
          do_grant = 1'b1;
          state_nx = ARB_START;
        end
      end
      ARB_START: if (SPIBUSY) state_nx = ARB_BUSY;
      ARB_BUSY: begin
        if (SPICOMPLETE) begin
          do_complete = 1'b1;
          state_nx    = ARB_DONE;
        end
      end
      ARB_DONE: state_nx = ARB_IDLE;
      default:  state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      GNT      <= '0;
      DONE     <= '0;
      LOCKED   <= 1'b0;
      TXSTART  <= 1'b0;
      CSSEL    <= '0;
      DWIDTH   <= '0;
      CPOL     <= 1'b0;
      CPHA     <= 1'b0;
      BORDER   <= 1'b0;
      CSEXTEND <= 1'b0;
      last     <= IW'(NREQ - 1);
      owner    <= '0;
      win_idx  <= '0;
    end else begin
      DONE <= '0;
      if (do_grant) begin
        GNT      <= pick_onehot;
        win_idx  <= pick_idx;
        last     <= pick_idx;
        TXSTART  <= 1'b1;
        CSSEL    <= REQ_CSSEL[CSSEL_W*pick_idx +: CSSEL_W];
        DWIDTH   <= REQ_DWIDTH[DWIDTH_W*pick_idx +: DWIDTH_W];
        CPOL     <= REQ_CPOL[pick_idx];
        CPHA     <= REQ_CPHA[pick_idx];
        BORDER   <= REQ_BORDER[pick_idx];
        CSEXTEND <= REQ_CSEXTEND[pick_idx];
      end
      if ((state == ARB_START) && SPIBUSY) TXSTART <= 1'b0;
      // Completion of a CS-extended transfer keeps GNT and makes the winner the lock owner.
      if (do_complete) begin
        DONE <= GNT;
        if (CSEXTEND) begin
          LOCKED <= 1'b1;
          owner  <= win_idx;
        end else begin
          LOCKED <= 1'b0;
          GNT    <= '0;
        end
      end
      if (abort_now) begin
        LOCKED <= 1'b0;
        GNT    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sc_spi_arb.sv
// Self-checking bench for sc_spi_arb: directed scenarios plus randomized traffic
// against a request-list reference model. Covers SC_SPI_ARB_LOCKTMO_EN when defined.
module tb_sc_spi_arb;

  localparam int N = 4;

  logic           SYSCLK = 1'b0;
  logic           SYSRST = 1'b1;
  logic [N-1:0]   REQ = '0;
  logic [5*N-1:0] REQ_CSSEL = '0;
  logic [9*N-1:0] REQ_DWIDTH = '0;
  logic [N-1:0]   REQ_CPOL = '0, REQ_CPHA = '0, REQ_BORDER = '0, REQ_CSEXTEND = '0;
  logic [N-1:0]   GNT, DONE;
  logic           LOCKED, TXSTART, CPOL, CPHA, BORDER, CSEXTEND;
  logic [4:0]     CSSEL;
  logic [8:0]     DWIDTH;
  logic           SPIBUSY = 1'b0, SPICOMPLETE = 1'b0;
`ifdef SC_SPI_ARB_LOCKTMO_EN
  logic           LOCK_ABORT;
`endif

  sc_spi_arb #(.NREQ(N), .LOCKTMO(16)) dut (
    .SYSCLK(SYSCLK), .SYSRST(SYSRST), .REQ(REQ),
    .REQ_CSSEL(REQ_CSSEL), .REQ_DWIDTH(REQ_DWIDTH), .REQ_CPOL(REQ_CPOL),
    .REQ_CPHA(REQ_CPHA), .REQ_BORDER(REQ_BORDER), .REQ_CSEXTEND(REQ_CSEXTEND),
    .GNT(GNT), .DONE(DONE), .LOCKED(LOCKED), .TXSTART(TXSTART),
    .CSSEL(CSSEL), .DWIDTH(DWIDTH), .CPOL(CPOL), .CPHA(CPHA),
    .BORDER(BORDER), .CSEXTEND(CSEXTEND),
    .SPIBUSY(SPIBUSY), .SPICOMPLETE(SPICOMPLETE)
`ifdef SC_SPI_ARB_LOCKTMO_EN
    , .LOCK_ABORT(LOCK_ABORT)
`endif
  );

  always #5 SYSCLK = ~SYSCLK;

  int tests = 0;
  int fails = 0;

  // Reference model: pending requests with their config, plus pointer and lock.
  bit         pend[N];
  logic [4:0] cs[N];
  logic [8:0] dw[N];
  bit         cpol_m[N], cpha_m[N], bo_m[N], cx_m[N];
  int         last_m;
  int         owner_m;
  bit         locked_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    last_m   = N - 1;
    owner_m  = 0;
    locked_m = 0;
  endtask

  task automatic set_req(input int i, input logic [4:0] c, input logic [8:0] d, input bit x);
    pend[i]   = 1;
    cs[i]     = c;
    dw[i]     = d;
    cpol_m[i] = 1'($urandom_range(0, 1));
    cpha_m[i] = 1'($urandom_range(0, 1));
    bo_m[i]   = 1'($urandom_range(0, 1));
    cx_m[i]   = x;
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      REQ[i]               = pend[i];
      REQ_CSSEL[5*i +: 5]  = cs[i];
      REQ_DWIDTH[9*i +: 9] = dw[i];
      REQ_CPOL[i]          = cpol_m[i];
      REQ_CPHA[i]          = cpha_m[i];
      REQ_BORDER[i]        = bo_m[i];
      REQ_CSEXTEND[i]      = cx_m[i];
    end
  endtask

  // Nearest pending requester after last_m in circular distance; owner only when locked.
  function automatic int exp_winner();
    int best = -1;
    int bd   = N;
    for (int i = 0; i < N; i++) begin
      if (pend[i] && (!locked_m || i == owner_m)) begin
        int d = (i - last_m - 1 + 2 * N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({GNT, DONE, LOCKED, TXSTART, CSSEL, DWIDTH, CPOL, CPHA, BORDER, CSEXTEND});
  endfunction

  // One full transfer with the stub: bdly cycles before SPIBUSY rises, blen busy cycles.
  task automatic run_xfer(input int bdly, input int blen);
    int w;
    logic [N-1:0] oh;
    w = exp_winner();
    if (w < 0) begin
      chk("winner_exists", 32'(0), 32'(1));
      return;
    end
    oh = '0;
    oh[w] = 1'b1;
    drive_req();
    tick();
    chk("gnt", 32'(GNT), 32'(oh));
    chk("txstart_set", 32'(TXSTART), 32'(1));
    chk("cssel", 32'(CSSEL), 32'(cs[w]));
    chk("dwidth", 32'(DWIDTH), 32'(dw[w]));
    chk("mode", 32'({CPOL, CPHA, BORDER, CSEXTEND}), 32'({cpol_m[w], cpha_m[w], bo_m[w], cx_m[w]}));
    last_m = w;
    REQ_CSSEL[5*w +: 5]  = ~cs[w];
    REQ_DWIDTH[9*w +: 9] = ~dw[w];
    for (int d = 0; d < bdly; d++) begin
      SPICOMPLETE = (d == 0);
      tick();
      chk("txstart_hold", 32'(TXSTART), 32'(1));
      chk("done_early", 32'(DONE), 32'(0));
      SPICOMPLETE = 1'b0;
    end
    SPIBUSY = 1'b1;
    tick();
    chk("txstart_clr", 32'(TXSTART), 32'(0));
    for (int b = 1; b < blen; b++) tick();
    SPIBUSY     = 1'b0;
    SPICOMPLETE = 1'b1;
    tick();
    if (cx_m[w]) begin
      locked_m = 1;
      owner_m  = w;
    end else begin
      locked_m = 0;
    end
    chk("done", 32'(DONE), 32'(oh));
    chk("locked_at_done", 32'(LOCKED), 32'(locked_m));
    chk("gnt_at_done", 32'(GNT), locked_m ? 32'(oh) : 32'(0));
    chk("cssel_latched", 32'(CSSEL), 32'(cs[w]));
    chk("dwidth_latched", 32'(DWIDTH), 32'(dw[w]));
    SPICOMPLETE = 1'b0;
    pend[w] = 0;
    drive_req();
    tick();
    chk("done_pulse_end", 32'(DONE), 32'(0));
    chk("gnt_idle", 32'(GNT), locked_m ? 32'(oh) : 32'(0));
    chk("txstart_idle", 32'(TXSTART), 32'(0));
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) begin
      cs[i] = '0; dw[i] = '0; cpol_m[i] = 0; cpha_m[i] = 0; bo_m[i] = 0; cx_m[i] = 0;
    end
    tick();
    tick();
    chk("reset_outputs", all_outs(), 32'(0));
    SYSRST = 1'b0;

    // Single request from reset
    set_req(0, 5'd3, 9'd8, 0);
    run_xfer(2, 2);

    // Round robin with all requesting
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) set_req(i, 5'(i + 8), 9'(16 + i), 0);
      run_xfer(r % 3, 1 + r % 2);
    end
    for (int i = 0; i < N; i++) pend[i] = 0;
    drive_req();
    tick();

    // Foreign busy holds off arbitration
    set_req(0, 5'd5, 9'd12, 0);
    SPIBUSY = 1'b1;
    drive_req();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("foreign_busy_gnt", 32'(GNT), 32'(0));
      chk("foreign_busy_tx", 32'(TXSTART), 32'(0));
    end
    SPIBUSY = 1'b0;
    run_xfer(1, 1);

    // Lock by requester 1, requester 2 waits until it is released
    set_req(1, 5'd1, 9'd32, 1);
    run_xfer(0, 2);
    chk("locked_after_cx", 32'(LOCKED), 32'(1));
    set_req(1, 5'd2, 9'd24, 0);
    set_req(2, 5'd9, 9'd7, 0);
    run_xfer(1, 1);
    chk("unlocked_after_release", 32'(LOCKED), 32'(0));
    run_xfer(0, 1);

    // Reset mid-transfer while locked
    set_req(1, 5'd4, 9'd64, 1);
    run_xfer(0, 1);
    set_req(1, 5'd6, 9'd40, 1);
    drive_req();
    tick();
    chk("relock_gnt", 32'(GNT), 32'(4'b0010));
    SPIBUSY = 1'b1;
    tick();
    #2 SYSRST = 1'b1;
    #1;
    chk("async_reset_outputs", all_outs(), 32'(0));
    SPIBUSY = 1'b0;
    model_reset();
    drive_req();
    #2 SYSRST = 1'b0;
    set_req(3, 5'd17, 9'd100, 0);
    run_xfer(0, 1);

`ifdef SC_SPI_ARB_LOCKTMO_EN
    begin
      int n;
      set_req(1, 5'd11, 9'd9, 1);
      run_xfer(0, 1);
      set_req(3, 5'd21, 9'd33, 0);
      drive_req();
      n = 0;
      while (LOCK_ABORT !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      chk("lock_abort_cycles", 32'(n), 32'(16));
      chk("abort_unlocked", 32'(LOCKED), 32'(0));
      chk("abort_gnt", 32'(GNT), 32'(0));
      locked_m = 0;
      run_xfer(0, 1);
      chk("lock_abort_pulse", 32'(LOCK_ABORT), 32'(0));
    end
`endif

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1)
          set_req(i, 5'($urandom_range(0, 31)), 9'($urandom_range(1, 511)), $urandom_range(0, 3) == 0);
      if (locked_m && !pend[owner_m])
        set_req(owner_m, 5'($urandom_range(0, 31)), 9'($urandom_range(1, 511)), $urandom_range(0, 2) == 0);
      if (exp_winner() < 0) set_req(int'($urandom_range(0, N - 1)), 5'($urandom_range(0, 31)), 9'($urandom_range(1, 511)), 0);
      if (exp_winner() < 0) set_req(owner_m, 5'($urandom_range(0, 31)), 9'($urandom_range(1, 511)), 0);
      run_xfer(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
